// File: rtl/mcm_index_scheduler_if.sv
// Handshake bundle between the matrix-chain DP scheduler and its datapath.
// The master modport is the scheduler side; the slave modport is the datapath/control side.
interface mcm_index_scheduler_if #(
  parameter int W = 8
);
  logic         start;
  logic [W-1:0] matlen;
  logic         busy;
  logic         done;
  logic         err;
  logic         idx_valid;
  logic         idx_ready;
  logic [W-1:0] ir;
  logic [W-1:0] jr;
  logic [W-1:0] kr;
  logic         rw;
  logic         wr_en;
  logic [W-1:0] iw;
  logic [W-1:0] jw;
  logic         wr_zero;

  modport master (
    input  start, matlen, idx_ready,
    output busy, done, err, idx_valid, ir, jr, kr, rw, wr_en, iw, jw, wr_zero
  );

  modport slave (
    output start, matlen, idx_ready,
    input  busy, done, err, idx_valid, ir, jr, kr, rw, wr_en, iw, jw, wr_zero
  );
endinterface

// File: rtl/mcm_index_scheduler.sv
// Matrix-chain-multiply DP index scheduler: walks the cost table diagonal by diagonal.
// Optional MCM_DIAG_INIT_EN adds a ZINIT phase that zero-writes the main diagonal.
module mcm_index_scheduler #(
  parameter int W     = 8,
  parameter int MAX_N = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mcm_index_scheduler_if.master  bus
);

  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] MAX_N_W = W'(MAX_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
`ifdef MCM_DIAG_INIT_EN
    S_ZINIT,
`endif
    S_ISSUE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t       r_state, w_state_nx;
  logic [W-1:0] r_n, w_n_nx;
  logic [W-1:0] r_d, w_d_nx;
  logic [W-1:0] r_i, w_i_nx;
  logic [W-1:0] r_j, w_j_nx;
  logic [W-1:0] r_k, w_k_nx;
`ifdef MCM_DIAG_INIT_EN
  logic [W-1:0] r_z, w_z_nx;
`endif

  logic         w_busy, w_done, w_err, w_valid, w_rw, w_wr_en, w_wr_zero;
  logic [W-1:0] w_ir, w_jr, w_kr, w_iw, w_jw;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_n     <= '0;
      r_d     <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
`ifdef MCM_DIAG_INIT_EN
      r_z     <= '0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_n     <= w_n_nx;
      r_d     <= w_d_nx;
      r_i     <= w_i_nx;
      r_j     <= w_j_nx;
      r_k     <= w_k_nx;
`ifdef MCM_DIAG_INIT_EN
      r_z     <= w_z_nx;
`endif
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nx = r_state;
    w_n_nx     = r_n;
    w_d_nx     = r_d;
    w_i_nx     = r_i;
    w_j_nx     = r_j;
    w_k_nx     = r_k;
`ifdef MCM_DIAG_INIT_EN
    w_z_nx     = r_z;
`endif
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_valid    = 1'b0;
    w_rw       = 1'b0;
    w_ir       = '0;
    w_jr       = '0;
    w_kr       = '0;
    w_wr_en    = 1'b0;
    w_wr_zero  = 1'b0;
    w_iw       = '0;
    w_jw       = '0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_n_nx     = bus.matlen;
          w_state_nx = S_INIT;
        end
      end

      S_INIT: begin
        w_busy = 1'b1;
        if (r_n > MAX_N_W || r_n < 2) begin
          w_state_nx = S_DONE;
        end else begin
          w_d_nx = ONE;
          w_i_nx = '0;
          w_k_nx = '0;
          w_j_nx = ONE;
`ifdef MCM_DIAG_INIT_EN
          w_z_nx     = '0;
          w_state_nx = S_ZINIT;
`else
          w_state_nx = S_ISSUE;
`endif
        end
      end

`ifdef MCM_DIAG_INIT_EN
      S_ZINIT: begin
        w_busy    = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_zero = 1'b1;
        w_iw      = r_z;
        w_jw      = r_z;
        w_z_nx    = r_z + ONE;
        if (r_z == r_n - ONE) w_state_nx = S_ISSUE;
      end
`endif

      S_ISSUE: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        w_ir    = r_i;
        w_jr    = r_j;
        w_kr    = r_k;
        w_rw    = (r_k == r_j - ONE);
        if (bus.idx_ready) begin
          if (w_rw) w_state_nx = S_WRITE;
          else      w_k_nx     = r_k + ONE;
        end
      end

      S_WRITE: begin
        w_busy  = 1'b1;
        w_wr_en = 1'b1;
        w_iw    = r_i;
        w_jw    = r_j;
        // Next cell: along the current diagonal, else start of the next one.
        if (r_i < r_n - ONE - r_d) begin
          w_i_nx     = r_i + ONE;
          w_k_nx     = r_i + ONE;
          w_j_nx     = r_i + ONE + r_d;
          w_state_nx = S_ISSUE;
        end else if (r_d < r_n - ONE) begin
          w_d_nx     = r_d + ONE;
          w_i_nx     = '0;
          w_k_nx     = '0;
          w_j_nx     = r_d + ONE;
          w_state_nx = S_ISSUE;
        end else begin
          w_state_nx = S_DONE;
        end
      end

      S_DONE: begin
        w_done     = 1'b1;
        w_err      = (r_n > MAX_N_W);
        w_state_nx = S_IDLE;
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.err       = w_err;
  assign bus.idx_valid = w_valid;
  assign bus.ir        = w_ir;
  assign bus.jr        = w_jr;
  assign bus.kr        = w_kr;
  assign bus.rw        = w_rw;
  assign bus.wr_en     = w_wr_en;
  assign bus.iw        = w_iw;
  assign bus.jw        = w_jw;
  assign bus.wr_zero   = w_wr_zero;

endmodule
